// File: rtl/sync_ram_clr_pkg.sv
// Shared types and constants for the sync_ram_clr memory slice.
package ram_pkg;

    // Clear sequencer states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // RD_MODE selector values
    localparam int unsigned RD_FIRST = 0;
    localparam int unsigned WR_FIRST = 1;

endpackage

// File: rtl/sync_ram_clr_if.sv
// Access/status bundle for sync_ram_clr: requester drives the master side.
interface sync_ram_clr_if #(
    parameter int unsigned DW = 4,
    parameter int unsigned AW = 2
);
    logic          EN;
    logic          WE;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic          CLR;
    logic [DW-1:0] Q;
    logic          QV;
    logic          BUSY;

    modport master (
        output EN, WE, A, D, CLR,
        input  Q, QV, BUSY
    );

    modport slave (
        input  EN, WE, A, D, CLR,
        output Q, QV, BUSY
    );
endinterface

// File: rtl/sync_ram_clr_seq.sv
// Clear sequencer: walks words 0..DEPTH-1 once after reset and on each CLR in IDLE.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int unsigned AW    = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CLR,
    output logic          BUSY,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    // Terminal word is DEPTH-1, which need not be the all-ones address
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_t    state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    // State and sweep counter; reset lands in CLEAR so every boot starts a sweep
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter advance and sweep write strobes
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        BUSY      = 1'b0;
        clr_we    = 1'b0;
        clr_addr  = cnt;
        unique case (state)
            ST_IDLE: begin
                if (CLR) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                BUSY   = 1'b1;
                clr_we = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/sync_ram_clr.sv
// Single-port synchronous RAM with registered read, read-valid pulse and clear sweep.
module sync_ram_clr
    import ram_pkg::*;
#(
    parameter int unsigned DW      = 4,
    parameter int unsigned AW      = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned RD_MODE = RD_FIRST,
    parameter              CLR_VAL = 0
) (
    input  logic          CLK,
    input  logic          RST_N,
    sync_ram_clr_if.slave bus
);

    localparam logic [DW-1:0] CLR_WORD = DW'(CLR_VAL);

    logic [DW-1:0] mem [DEPTH];

    logic          busy;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          in_range;
    logic          access;
    logic          port_we;
    logic [DW-1:0] rd_word;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    ram_clr_seq #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_seq (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CLR      (bus.CLR),
        .BUSY     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign bus.BUSY = busy;
    assign in_range = ({1'b0, bus.A} < (AW + 1)'(DEPTH));
    assign access   = bus.EN && !busy;
    assign port_we  = access && !bus.WE && in_range;
    assign rd_word  = in_range ? mem[bus.A] : '0;

    // Single array write port: sweep owns it while busy, otherwise the access port
    always_comb begin
        wr_en   = clr_we | port_we;
        wr_addr = bus.A;
        wr_data = bus.D;
        if (clr_we) begin
            wr_addr = clr_addr;
            wr_data = CLR_WORD;
        end
    end

    // Array storage; contents are not reset, the sweep initialises them
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read data and valid pulse; the sweep never touches Q
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.Q  <= '0;
            bus.QV <= 1'b0;
        end else begin
            bus.QV <= access;
            if (access) begin
                if (!bus.WE && (RD_MODE == WR_FIRST)) begin
                    bus.Q <= bus.D;
                end else begin
                    bus.Q <= rd_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_ram_clr.sv
// Directed bench for sync_ram_clr: read-first, write-first and non-power-of-two depth instances.
module tb_sync_ram_clr;
    import ram_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sync_ram_clr_if #(.DW(4), .AW(2)) if0 ();
    sync_ram_clr_if #(.DW(4), .AW(2)) if1 ();
    sync_ram_clr_if #(.DW(8), .AW(3)) if2 ();

    sync_ram_clr #(
        .DW(4), .AW(2), .DEPTH(4), .RD_MODE(RD_FIRST), .CLR_VAL(4'hA)
    ) u0 (
        .CLK(clk), .RST_N(rst_n), .bus(if0.slave)
    );

    sync_ram_clr #(
        .DW(4), .AW(2), .DEPTH(4), .RD_MODE(WR_FIRST), .CLR_VAL(4'hA)
    ) u1 (
        .CLK(clk), .RST_N(rst_n), .bus(if1.slave)
    );

    sync_ram_clr #(
        .DW(8), .AW(3), .DEPTH(6), .RD_MODE(RD_FIRST), .CLR_VAL(8'h5C)
    ) u2 (
        .CLK(clk), .RST_N(rst_n), .bus(if2.slave)
    );

    typedef struct {
        logic       en;
        logic       we;
        logic [1:0] a;
        logic [3:0] d;
        logic       clr;
        logic [3:0] q0;
        logic [3:0] q1;
        logic       qv;
        logic       busy;
    } vec_t;

    localparam int NVEC = 25;
    vec_t tbl [NVEC];

    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(input logic en, input logic we, input logic [1:0] a,
                                input logic [3:0] d, input logic clr, input logic [3:0] q0,
                                input logic [3:0] q1, input logic qv, input logic busy);
        vec_t v;
        v.en = en; v.we = we; v.a = a; v.d = d; v.clr = clr;
        v.q0 = q0; v.q1 = q1; v.qv = qv; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drv4(input logic en, input logic we, input logic [1:0] a,
                        input logic [3:0] d, input logic clr);
        if0.EN = en; if0.WE = we; if0.A = a; if0.D = d; if0.CLR = clr;
        if1.EN = en; if1.WE = we; if1.A = a; if1.D = d; if1.CLR = clr;
    endtask

    task automatic drv8(input logic en, input logic we, input logic [2:0] a,
                        input logic [7:0] d, input logic clr);
        if2.EN = en; if2.WE = we; if2.A = a; if2.D = d; if2.CLR = clr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Columns: en we a d clr | q(read-first) q(write-first) qv busy
        tbl[0]  = mk(1, 1, 2'd0, 4'h0, 0, 4'h0, 4'h0, 0, 1);
        tbl[1]  = mk(0, 0, 2'd0, 4'h0, 0, 4'h0, 4'h0, 0, 1);
        tbl[2]  = mk(0, 0, 2'd0, 4'h0, 0, 4'h0, 4'h0, 0, 1);
        tbl[3]  = mk(0, 0, 2'd0, 4'h0, 0, 4'h0, 4'h0, 0, 0);
        tbl[4]  = mk(1, 1, 2'd0, 4'h0, 0, 4'hA, 4'hA, 1, 0);
        tbl[5]  = mk(1, 1, 2'd1, 4'h0, 0, 4'hA, 4'hA, 1, 0);
        tbl[6]  = mk(1, 1, 2'd2, 4'h0, 0, 4'hA, 4'hA, 1, 0);
        tbl[7]  = mk(1, 1, 2'd3, 4'h0, 0, 4'hA, 4'hA, 1, 0);
        tbl[8]  = mk(1, 0, 2'd2, 4'h5, 0, 4'hA, 4'h5, 1, 0);
        tbl[9]  = mk(1, 1, 2'd2, 4'h0, 0, 4'h5, 4'h5, 1, 0);
        tbl[10] = mk(1, 0, 2'd1, 4'h3, 0, 4'hA, 4'h3, 1, 0);
        tbl[11] = mk(1, 1, 2'd1, 4'h0, 0, 4'h3, 4'h3, 1, 0);
        tbl[12] = mk(0, 1, 2'd1, 4'h0, 0, 4'h3, 4'h3, 0, 0);
        tbl[13] = mk(1, 0, 2'd0, 4'h7, 1, 4'hA, 4'h7, 1, 1);
        tbl[14] = mk(1, 1, 2'd2, 4'h0, 0, 4'hA, 4'h7, 0, 1);
        tbl[15] = mk(1, 0, 2'd2, 4'h1, 0, 4'hA, 4'h7, 0, 1);
        tbl[16] = mk(1, 1, 2'd1, 4'h0, 0, 4'hA, 4'h7, 0, 1);
        tbl[17] = mk(1, 1, 2'd3, 4'h0, 0, 4'hA, 4'h7, 0, 0);
        tbl[18] = mk(1, 1, 2'd0, 4'h0, 0, 4'hA, 4'hA, 1, 0);
        tbl[19] = mk(1, 1, 2'd2, 4'h0, 0, 4'hA, 4'hA, 1, 0);
        tbl[20] = mk(1, 1, 2'd1, 4'h0, 0, 4'hA, 4'hA, 1, 0);
        tbl[21] = mk(1, 0, 2'd3, 4'hC, 0, 4'hA, 4'hC, 1, 0);
        tbl[22] = mk(1, 1, 2'd3, 4'h0, 0, 4'hC, 4'hC, 1, 0);
        tbl[23] = mk(1, 0, 2'd3, 4'hE, 0, 4'hC, 4'hE, 1, 0);
        tbl[24] = mk(1, 1, 2'd3, 4'h0, 0, 4'hE, 4'hE, 1, 0);

        // Reset state
        rst_n = 1'b0;
        drv4(0, 0, 2'd0, 4'h0, 0);
        drv8(0, 0, 3'd0, 8'h00, 0);
        step;
        chk("reset q", if0.Q, 4'h0);
        chk("reset qv", if0.QV, 1'b0);
        chk("reset busy", if0.BUSY, 1'b1);
        chk("reset busy dw8", if2.BUSY, 1'b1);
        rst_n = 1'b1;

        // Post-reset sweep and main access patterns, both read modes
        for (int i = 0; i < NVEC; i++) begin
            drv4(tbl[i].en, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].clr);
            step;
            chk($sformatf("r%0d q rdfirst", i), if0.Q, tbl[i].q0);
            chk($sformatf("r%0d q wrfirst", i), if1.Q, tbl[i].q1);
            chk($sformatf("r%0d qv rdfirst", i), if0.QV, tbl[i].qv);
            chk($sformatf("r%0d qv wrfirst", i), if1.QV, tbl[i].qv);
            chk($sformatf("r%0d busy", i), if0.BUSY, tbl[i].busy);
            chk($sformatf("r%0d busy wrfirst", i), if1.BUSY, tbl[i].busy);
            if (i < 8) begin
                chk($sformatf("r%0d busy dw8 reset sweep", i), if2.BUSY, (i < 5) ? 1 : 0);
            end
        end
        drv4(0, 0, 2'd0, 4'h0, 0);

        // DW=8/DEPTH=6: last word, out-of-range drop, 6-cycle sweep
        drv8(1, 1, 3'd5, 8'h00, 0); step;
        chk("dw8 read a5", if2.Q, 8'h5C);
        chk("dw8 read a5 qv", if2.QV, 1'b1);
        drv8(1, 0, 3'd7, 8'hFF, 0); step;
        drv8(1, 1, 3'd3, 8'h00, 0); step;
        chk("dw8 read a3", if2.Q, 8'h5C);
        drv8(1, 1, 3'd7, 8'h00, 0); step;
        chk("dw8 read a7 q", if2.Q, 8'h00);
        chk("dw8 read a7 qv", if2.QV, 1'b1);
        drv8(1, 0, 3'd5, 8'h33, 0); step;
        drv8(1, 1, 3'd5, 8'h00, 0); step;
        chk("dw8 write/read a5", if2.Q, 8'h33);
        drv8(1, 1, 3'd0, 8'h00, 0); step;
        chk("dw8 read a0", if2.Q, 8'h5C);
        drv8(0, 0, 3'd0, 8'h00, 1); step;
        chk("dw8 clr busy start", if2.BUSY, 1'b1);
        for (int k = 0; k < 5; k++) begin
            // CLR held for the first few sweep cycles must not extend the sweep
            drv8(1, 1, 3'd5, 8'h00, (k < 3) ? 1'b1 : 1'b0);
            step;
            chk($sformatf("dw8 sweep busy c%0d", k + 1), if2.BUSY, 1'b1);
            chk($sformatf("dw8 sweep qv c%0d", k + 1), if2.QV, 1'b0);
            chk($sformatf("dw8 sweep q hold c%0d", k + 1), if2.Q, 8'h5C);
        end
        drv8(0, 0, 3'd0, 8'h00, 0); step;
        chk("dw8 sweep end busy", if2.BUSY, 1'b0);
        drv8(1, 1, 3'd5, 8'h00, 0); step;
        chk("dw8 read a5 after clr", if2.Q, 8'h5C);
        drv8(0, 0, 3'd0, 8'h00, 0);

        // Reset in the middle of an on-demand sweep restarts it from word 0
        drv4(0, 0, 2'd0, 4'h0, 1); step;
        chk("midrst clr busy", if0.BUSY, 1'b1);
        drv4(0, 0, 2'd0, 4'h0, 0);
        step;
        step;
        rst_n = 1'b0;
        #1;
        chk("midrst q", if0.Q, 4'h0);
        chk("midrst qv", if0.QV, 1'b0);
        chk("midrst busy", if0.BUSY, 1'b1);
        step;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step;
            chk($sformatf("midrst busy c%0d", k + 1), if0.BUSY, 1'b1);
        end
        step;
        chk("midrst busy end", if0.BUSY, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drv4(1, 1, 2'(k), 4'h0, 0);
            step;
            chk($sformatf("midrst read a%0d", k), if0.Q, 4'hA);
            chk($sformatf("midrst read a%0d wrfirst", k), if1.Q, 4'hA);
            chk($sformatf("midrst read a%0d qv", k), if0.QV, 1'b1);
        end
        drv4(0, 0, 2'd0, 4'h0, 0);
        step;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
